market_bar_reader: RTL and testbench

//  Consumer stage of bram_storage. Walks a contiguous range of stored OHLCV rows,

---
 rtl/market_bar_reader.sv | 172 +++++++++++++++++
 tb/tb_market_bar_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/market_bar_reader.sv
// Walks a row range of bram_storage, reads the six OHLCV columns per row and presents
// each row as one bar over valid/ready. Optional range/sign check under `BAR_CHECK_EN`.
module market_bar_reader #(
   parameter int ROW_W  = 10,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [ROW_W-1:0] first_row,
   input  logic [ROW_W:0]   num_rows,
   output logic [ROW_W-1:0] row_index,
   output logic [2:0]       col_index,
   input  logic [31:0]      bram_data,
   output logic             bar_valid,
   input  logic             bar_ready,
   output logic [ROW_W-1:0] bar_row,
   output logic [31:0]      bar_ts,
   output logic [31:0]      bar_open,
   output logic [31:0]      bar_high,
   output logic [31:0]      bar_low,
   output logic [31:0]      bar_close,
   output logic [31:0]      bar_vol,
`ifdef BAR_CHECK_EN
   output logic             bar_err,
`endif
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

   localparam logic [ROW_W:0]   MAX_ROWS = {1'b1, {ROW_W{1'b0}}};
   localparam logic [ROW_W:0]   ONE_ROW  = {{ROW_W{1'b0}}, 1'b1};
   localparam logic [ROW_W-1:0] ROW_STEP = {{(ROW_W-1){1'b0}}, 1'b1};
   localparam logic [2:0]       LAST_COL = 3'd5;

   state_t           state;
   logic [ROW_W:0]   rows_left;
   logic [RD_LAT-1:0] tag_vld_p;
   logic [2:0]       tag_col_p [RD_LAT];
   logic             cap_vld;
   logic [2:0]       cap_col;

   function automatic logic [ROW_W:0] sat_rows(input logic [ROW_W:0] n);
      if (n > MAX_ROWS)
         return MAX_ROWS;
      return n;
   endfunction

`ifdef BAR_CHECK_EN
   // Magnitude compare on [30:0] orders non-negative floats correctly.
   function automatic logic bar_check(input logic [31:0] o, input logic [31:0] h,
                                      input logic [31:0] l, input logic [31:0] c,
                                      input logic [31:0] v);
      logic sign_bad;
      logic range_bad;
      logic oc_bad;
      sign_bad  = o[31] | h[31] | l[31] | c[31] | v[31];
      range_bad = h[30:0] < l[30:0];
      oc_bad    = (o[30:0] < l[30:0]) | (o[30:0] > h[30:0]) |
                  (c[30:0] < l[30:0]) | (c[30:0] > h[30:0]);
      return sign_bad | range_bad | oc_bad;
   endfunction
`endif

   assign cap_vld = tag_vld_p[RD_LAT-1];
   assign cap_col = tag_col_p[RD_LAT-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         rows_left <= '0;
         row_index <= '0;
         col_index <= '0;
         bar_valid <= 1'b0;
         bar_row   <= '0;
         bar_ts    <= '0;
         bar_open  <= '0;
         bar_high  <= '0;
         bar_low   <= '0;
         bar_close <= '0;
         bar_vol   <= '0;
`ifdef BAR_CHECK_EN
         bar_err   <= 1'b0;
`endif
         busy      <= 1'b0;
         done      <= 1'b0;
         tag_vld_p <= '0;
         for (int k = 0; k < RD_LAT; k++)
            tag_col_p[k] <= '0;
      end else begin
         done <= 1'b0;

         // Stage p0..pN: column tag follows the read port by RD_LAT cycles
         tag_vld_p[0] <= (state == S_FETCH);
         tag_col_p[0] <= col_index;
         for (int k = 1; k < RD_LAT; k++) begin
            tag_vld_p[k] <= tag_vld_p[k-1];
            tag_col_p[k] <= tag_col_p[k-1];
         end

         // Capture stage: returning word lands in the field named by its tag
         if (cap_vld) begin
            case (cap_col)
               3'd0:    bar_ts    <= bram_data;
               3'd1:    bar_open  <= bram_data;
               3'd2:    bar_high  <= bram_data;
               3'd3:    bar_low   <= bram_data;
               3'd4:    bar_close <= bram_data;
               3'd5:    bar_vol   <= bram_data;
               default: ;
            endcase
         end

         case (state)
            S_IDLE: begin
               col_index <= '0;
               if (start) begin
                  if (num_rows == '0) begin
                     done <= 1'b1;
                  end else begin
                     row_index <= first_row;
                     rows_left <= sat_rows(num_rows);
                     busy      <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               if (col_index == LAST_COL) begin
                  col_index <= '0;
                  state     <= S_WAIT;
               end else begin
                  col_index <= col_index + 3'd1;
               end
            end

            S_WAIT: begin
               if (cap_vld && cap_col == LAST_COL) begin
                  bar_valid <= 1'b1;
                  bar_row   <= row_index;
`ifdef BAR_CHECK_EN
                  bar_err   <= bar_check(bar_open, bar_high, bar_low, bar_close, bram_data);
`endif
                  state     <= S_HOLD;
               end
            end

            S_HOLD: begin
               // Next row is only fetched after this bar has been taken.
               if (bar_ready) begin
                  bar_valid <= 1'b0;
                  rows_left <= rows_left - ONE_ROW;
                  if (rows_left == ONE_ROW) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     row_index <= row_index + ROW_STEP;
                     state     <= S_FETCH;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_market_bar_reader.sv
// Scoreboard bench for market_bar_reader: one instance at RD_LAT=1, one at RD_LAT=3,
// each fed by a behavioural bram_storage model of matching latency.
module tb_market_bar_reader;

   typedef struct packed {
      logic [9:0]  row;
      logic [31:0] ts, o, h, l, c, v;
      logic        err;
   } bar_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start1, start3;
   logic [9:0]  first1, first3;
   logic [10:0] num1, num3;
   logic [9:0]  ri1, ri3, brow1, brow3;
   logic [2:0]  ci1, ci3;
   logic [31:0] bd1, bd3;
   logic        bv1, bv3, br1, br3;
   logic [31:0] ts1, o1, h1, l1, c1, v1;
   logic [31:0] ts3, o3, h3, l3, c3, v3;
   logic        busy1, busy3, done1, done3;
   logic        err1, err3;

   logic [31:0] mem [1024][8];
   logic        err_tab [1024];
   bar_t        q1[$], q3[$];
   int          hs1[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_cnt1 = 0;
   int          done_cnt3 = 0;
   bar_t        e1, e3;
   logic [9:0]  r3a, r3b;
   logic [2:0]  c3a, c3b;

   market_bar_reader #(.ROW_W(10), .RD_LAT(1)) u1 (
`ifdef BAR_CHECK_EN
      .bar_err(err1),
`endif
      .clk(clk), .reset(reset), .start(start1), .first_row(first1), .num_rows(num1),
      .row_index(ri1), .col_index(ci1), .bram_data(bd1), .bar_valid(bv1), .bar_ready(br1),
      .bar_row(brow1), .bar_ts(ts1), .bar_open(o1), .bar_high(h1), .bar_low(l1),
      .bar_close(c1), .bar_vol(v1), .busy(busy1), .done(done1));

   market_bar_reader #(.ROW_W(10), .RD_LAT(3)) u3 (
`ifdef BAR_CHECK_EN
      .bar_err(err3),
`endif
      .clk(clk), .reset(reset), .start(start3), .first_row(first3), .num_rows(num3),
      .row_index(ri3), .col_index(ci3), .bram_data(bd3), .bar_valid(bv3), .bar_ready(br3),
      .bar_row(brow3), .bar_ts(ts3), .bar_open(o3), .bar_high(h3), .bar_low(l3),
      .bar_close(c3), .bar_vol(v3), .busy(busy3), .done(done3));

`ifndef BAR_CHECK_EN
   assign err1 = 1'b0;
   assign err3 = 1'b0;
`endif

   // bram_storage models: data_out changes RD_LAT edges after the index changes
   always @(posedge clk) begin
      cyc <= cyc + 1;
      bd1 <= mem[ri1][ci1];
      r3a <= ri3;
      c3a <= ci3;
      r3b <= r3a;
      c3b <= c3a;
      bd3 <= mem[r3b][c3b];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic bar_t exp_bar(input int r);
      bar_t b;
      b.row = 10'(r);
      b.ts  = mem[r][0];
      b.o   = mem[r][1];
      b.h   = mem[r][2];
      b.l   = mem[r][3];
      b.c   = mem[r][4];
      b.v   = mem[r][5];
      b.err = err_tab[r];
      return b;
   endfunction

   task automatic cmp_bar(input string tag, input bar_t e, input logic [9:0] row,
                          input logic [31:0] ts, input logic [31:0] o, input logic [31:0] h,
                          input logic [31:0] l, input logic [31:0] c, input logic [31:0] v,
                          input logic err);
      chk({tag, " bar_row"},   64'(row), 64'(e.row));
      chk({tag, " bar_ts"},    64'(ts),  64'(e.ts));
      chk({tag, " bar_open"},  64'(o),   64'(e.o));
      chk({tag, " bar_high"},  64'(h),   64'(e.h));
      chk({tag, " bar_low"},   64'(l),   64'(e.l));
      chk({tag, " bar_close"}, 64'(c),   64'(e.c));
      chk({tag, " bar_vol"},   64'(v),   64'(e.v));
`ifdef BAR_CHECK_EN
      chk({tag, " bar_err"},   64'(err), 64'(e.err));
`else
      if (err !== 1'b0) chk({tag, " bar_err tie"}, 64'(err), 64'd0);
`endif
   endtask

   // Monitors: pop the scoreboard on every handshake
   always @(negedge clk) begin
      if (reset === 1'b1 && bv1 && br1) begin
         hs1.push_back(cyc);
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u1 unexpected bar row=%0d", brow1);
         end else begin
            e1 = q1.pop_front();
            cmp_bar("u1", e1, brow1, ts1, o1, h1, l1, c1, v1, err1);
         end
      end
      if (reset === 1'b1 && done1) done_cnt1++;
   end

   always @(negedge clk) begin
      if (reset === 1'b1 && bv3 && br3) begin
         if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u3 unexpected bar row=%0d", brow3);
         end else begin
            e3 = q3.pop_front();
            cmp_bar("u3", e3, brow3, ts3, o3, h3, l3, c3, v3, err3);
         end
      end
      if (reset === 1'b1 && done3) done_cnt3++;
   end

   task automatic do_start(input int sel, input logic [9:0] f, input logic [10:0] n);
      @(negedge clk);
      if (sel == 1) begin
         start1 = 1'b1; first1 = f; num1 = n;
      end else begin
         start3 = 1'b1; first3 = f; num3 = n;
      end
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_idle(input int sel, input int budget, input string name);
      int n;
      n = 0;
      while (((sel == 1) ? busy1 : busy3) !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, " idle within budget"}, 64'((sel == 1) ? busy1 : busy3), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      int cnt, d0;
      logic [31:0] s_ts, s_v, s_h;

      for (int r = 0; r < 1024; r++) begin
         mem[r][0] = 32'h1000_0000 + r;
         mem[r][3] = 32'h4200_0000 + (r << 4);
         mem[r][1] = mem[r][3] + 1;
         mem[r][4] = mem[r][3] + 2;
         mem[r][2] = mem[r][3] + 3;
         mem[r][5] = 32'h4400_0000 + r;
         mem[r][6] = '0;
         mem[r][7] = '0;
         err_tab[r] = 1'b0;
      end
      // Row 100: high (100.0) below low (101.0)
      mem[100][2] = 32'h42C8_0000;
      mem[100][3] = 32'h42CA_0000;
      mem[100][1] = 32'h42C9_0000;
      mem[100][4] = 32'h42C9_0000;
      err_tab[100] = 1'b1;

      reset = 1'b0;
      start1 = 1'b0; start3 = 1'b0;
      first1 = '0; first3 = '0; num1 = '0; num3 = '0;
      br1 = 1'b1; br3 = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset bar_valid", 64'(bv1), 64'd0);
      chk("reset busy", 64'(busy1), 64'd0);
      chk("reset done", 64'(done1), 64'd0);
      chk("reset row_index", 64'(ri1), 64'd0);
      chk("reset col_index", 64'(ci1), 64'd0);
      chk("reset bar_ts", 64'(ts1), 64'd0);
      chk("reset u3 busy", 64'(busy3), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Reset in the middle of FETCH, at col 3
      do_start(1, 10'd10, 11'd1);
      cnt = 0;
      while (ci1 !== 3'd3 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("t1 reached col3", 64'(ci1), 64'd3);
      chk("t1 ts before reset", 64'(ts1), 64'(mem[10][0]));
      chk("t1 open before reset", 64'(o1), 64'(mem[10][1]));
      d0 = done_cnt1;
      reset = 1'b0;
      #1;
      chk("t1 row_index cleared", 64'(ri1), 64'd0);
      chk("t1 col_index cleared", 64'(ci1), 64'd0);
      chk("t1 bar_ts cleared", 64'(ts1), 64'd0);
      chk("t1 bar_open cleared", 64'(o1), 64'd0);
      chk("t1 busy cleared", 64'(busy1), 64'd0);
      chk("t1 done low", 64'(done1), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("t1 no done pulse", 64'(done_cnt1), 64'(d0));
      chk("t1 idle after release", 64'(busy1), 64'd0);

      // Three rows at RD_LAT=1 with ready held high
      hs1.delete();
      for (int r = 5; r < 8; r++) q1.push_back(exp_bar(r));
      d0 = done_cnt1;
      do_start(1, 10'd5, 11'd3);
      cnt = 1;
      while (bv1 !== 1'b1 && cnt < 60) begin
         @(negedge clk);
         cnt++;
      end
      chk("t2 first valid latency", 64'(cnt - 1), 64'd7);
      wait_idle(1, 200, "t2");
      chk("t2 bar count", 64'(hs1.size()), 64'd3);
      if (hs1.size() == 3) begin
         chk("t2 spacing 1", 64'(hs1[1] - hs1[0]), 64'd8);
         chk("t2 spacing 2", 64'(hs1[2] - hs1[1]), 64'd8);
      end
      chk("t2 one done", 64'(done_cnt1 - d0), 64'd1);
      chk("t2 queue drained", 64'(q1.size()), 64'd0);

      // Backpressure: ready low for 10 cycles on the first bar
      br1 = 1'b0;
      q1.push_back(exp_bar(20));
      q1.push_back(exp_bar(21));
      do_start(1, 10'd20, 11'd2);
      cnt = 0;
      while (bv1 !== 1'b1 && cnt < 60) begin
         @(negedge clk);
         cnt++;
      end
      chk("t3 valid seen", 64'(bv1), 64'd1);
      s_ts = ts1; s_v = v1; s_h = h1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3 valid held", 64'(bv1), 64'd1);
         chk("t3 ts stable", 64'(ts1), 64'(s_ts));
         chk("t3 high stable", 64'(h1), 64'(s_h));
         chk("t3 vol stable", 64'(v1), 64'(s_v));
         chk("t3 col_index 0", 64'(ci1), 64'd0);
         chk("t3 row_index held", 64'(ri1), 64'd20);
      end
      br1 = 1'b1;
      wait_idle(1, 200, "t3");
      chk("t3 queue drained", 64'(q1.size()), 64'd0);

      // Row wrap, then a zero-length scan
      q1.push_back(exp_bar(1023));
      q1.push_back(exp_bar(0));
      do_start(1, 10'd1023, 11'd2);
      wait_idle(1, 200, "t4 wrap");
      chk("t4 queue drained", 64'(q1.size()), 64'd0);
      d0 = done_cnt1;
      do_start(1, 10'd0, 11'd0);
      chk("t4 zero done pulse", 64'(done1), 64'd1);
      chk("t4 zero no valid", 64'(bv1), 64'd0);
      chk("t4 zero not busy", 64'(busy1), 64'd0);
      @(negedge clk);
      chk("t4 zero done one cycle", 64'(done1), 64'd0);
      chk("t4 zero still no valid", 64'(bv1), 64'd0);

      // Oversized num_rows saturates to a full 1024-row scan
      for (int r = 0; r < 1024; r++) q1.push_back(exp_bar(r));
      d0 = done_cnt1;
      do_start(1, 10'd0, 11'd2000);
      wait_idle(1, 9000, "sat");
      chk("sat queue drained", 64'(q1.size()), 64'd0);
      chk("sat one done", 64'(done_cnt1 - d0), 64'd1);

      // RD_LAT=3 latency and start ignored while busy
      q3.push_back(exp_bar(50));
      q3.push_back(exp_bar(51));
      d0 = done_cnt3;
      do_start(3, 10'd50, 11'd2);
      cnt = 1;
      while (bv3 !== 1'b1 && cnt < 60) begin
         if (cnt == 3) begin
            start3 = 1'b1; first3 = 10'd200; num3 = 11'd5;
         end else begin
            start3 = 1'b0;
         end
         @(negedge clk);
         cnt++;
      end
      start3 = 1'b0;
      chk("t5 first valid latency", 64'(cnt - 1), 64'd9);
      wait_idle(3, 200, "t5");
      chk("t5 queue drained", 64'(q3.size()), 64'd0);
      chk("t5 one done", 64'(done_cnt3 - d0), 64'd1);

`ifdef BAR_CHECK_EN
      // Inverted high/low flags an error; the following row is consistent
      q1.push_back(exp_bar(100));
      q1.push_back(exp_bar(101));
      do_start(1, 10'd100, 11'd2);
      wait_idle(1, 200, "t6");
      chk("t6 queue drained", 64'(q1.size()), 64'd0);
`endif

      repeat (5) @(negedge clk);
      chk("final u1 queue empty", 64'(q1.size()), 64'd0);
      chk("final u3 queue empty", 64'(q3.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
